gnr_attractor_ctrl: RTL and testbench

Run controller and attractor detector for a gene-regulatory-network node array. It drives the tortoise/hare stepping strobes for every node: `reset_nos`, `start_s0`, `start_s1` and `init_state`. It collects the two state vectors `s0` (tortoise, advancing every other step) and `s1` (hare, advancing every step). It finds where the trajectory becomes cyclic and measures the attractor period. It sits between the host-side job interface and the node array, one instance per network copy.

---
 rtl/gnr_ctrl_pkg.sv | 22 ++
 rtl/gnr_attractor_ctrl_if.sv | 23 ++
 rtl/gnr_state_cmp.sv | 10 +
 rtl/gnr_attractor_ctrl.sv | 155 +++++++++++++++
 tb/tb_gnr_attractor_ctrl.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/gnr_ctrl_pkg.sv
// rtl/gnr_ctrl_pkg.sv - shared types and constants for the GRN attractor controller
package gnr_ctrl_pkg;

  localparam int GNR_CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RUN    = 3'd2,
    ST_PERIOD = 3'd3,
    ST_DONE   = 3'd4
  } gnr_state_e;

  // Step budget clipped to what a cnt_w-bit counter can hold.
  function automatic int unsigned gnr_sat_limit(input int unsigned max_steps,
                                                input int unsigned cnt_w);
    int unsigned full;
    full = (cnt_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << cnt_w) - 32'd1);
    return (max_steps < full) ? max_steps : full;
  endfunction

endpackage

// File: rtl/gnr_attractor_ctrl_if.sv
// rtl/gnr_attractor_ctrl_if.sv - host-side job interface of the attractor controller
interface gnr_attractor_ctrl_if #(
  parameter int NUM_NODES = 32,
  parameter int CNT_W     = 16
);
  logic                 start;
  logic [NUM_NODES-1:0] init_in;
  logic                 busy;
  logic                 done;
  logic                 timeout;
  logic [CNT_W-1:0]     meet_step;
  logic [CNT_W-1:0]     period;

  modport master (
    output start, init_in,
    input  busy, done, timeout, meet_step, period
  );

  modport slave (
    input  start, init_in,
    output busy, done, timeout, meet_step, period
  );
endinterface

// File: rtl/gnr_state_cmp.sv
// rtl/gnr_state_cmp.sv - NUM_NODES-wide state vector equality compare
module gnr_state_cmp #(
  parameter int NUM_NODES = 32
) (
  input  logic [NUM_NODES-1:0] a_i,
  input  logic [NUM_NODES-1:0] b_i,
  output logic                 eq_o
);
  assign eq_o = (a_i == b_i);
endmodule

// File: rtl/gnr_attractor_ctrl.sv
// rtl/gnr_attractor_ctrl.sv - tortoise/hare run controller and attractor detector
// The period measurement phase is built only when GNR_CTRL_PERIOD_EN is defined.
module gnr_attractor_ctrl
  import gnr_ctrl_pkg::*;
#(
  parameter int          NUM_NODES = 32,
  parameter int          CNT_W     = GNR_CNT_W,
  parameter int unsigned MAX_STEPS = 32'h0000_FFFF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gnr_attractor_ctrl_if.slave  host,
  input  logic [NUM_NODES-1:0] s0_vec,
  input  logic [NUM_NODES-1:0] s1_vec,
  output logic                 reset_nos,
  output logic [NUM_NODES-1:0] init_state,
  output logic                 start_s0,
  output logic                 start_s1
);

  localparam logic [2:0] S_IDLE   = ST_IDLE;
  localparam logic [2:0] S_LOAD   = ST_LOAD;
  localparam logic [2:0] S_RUN    = ST_RUN;
  localparam logic [2:0] S_DONE   = ST_DONE;
`ifdef GNR_CTRL_PERIOD_EN
  localparam logic [2:0] S_PERIOD = ST_PERIOD;
`endif

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(gnr_sat_limit(MAX_STEPS, CNT_W));
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     step_q, step_d;
  logic [CNT_W-1:0]     meet_q, meet_d;
  logic                 timeout_q, timeout_d;
  logic [NUM_NODES-1:0] init_q, init_d;
  logic                 vec_eq;
  logic                 match;
`ifdef GNR_CTRL_PERIOD_EN
  logic [CNT_W-1:0]     per_q, per_d;
  logic [CNT_W-1:0]     period_q, period_d;
`endif

  gnr_state_cmp #(.NUM_NODES(NUM_NODES)) u_cmp (
    .a_i  (s0_vec),
    .b_i  (s1_vec),
    .eq_o (vec_eq)
  );

  // Vectors only mean something at even, nonzero hare steps (tortoise at half).
  assign match = (state_q == S_RUN) && vec_eq && !step_q[0] && (step_q != '0);

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    meet_d    = meet_q;
    timeout_d = timeout_q;
    init_d    = init_q;
    start_s0  = 1'b0;
    start_s1  = 1'b0;
`ifdef GNR_CTRL_PERIOD_EN
    per_d     = per_q;
    period_d  = period_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (host.start) begin
          init_d    = host.init_in;
          step_d    = '0;
          meet_d    = '0;
          timeout_d = 1'b0;
`ifdef GNR_CTRL_PERIOD_EN
          per_d     = '0;
          period_d  = '0;
`endif
          state_d   = S_LOAD;
        end
      end
      S_LOAD: state_d = S_RUN;
      S_RUN: begin
        if (match) begin
          meet_d  = step_q;
`ifdef GNR_CTRL_PERIOD_EN
          state_d = S_PERIOD;
`else
          state_d = S_DONE;
`endif
        end else if (step_q == MAX_C) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          start_s0 = 1'b1;
          start_s1 = 1'b1;
          step_d   = step_q + ONE_C;
        end
      end
`ifdef GNR_CTRL_PERIOD_EN
      // Tortoise parked on the cycle; hare walks until it comes back around.
      S_PERIOD: begin
        if ((per_q != '0) && vec_eq) begin
          period_d = per_q;
          state_d  = S_DONE;
        end else if (per_q == MAX_C) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          start_s1 = 1'b1;
          per_d    = per_q + ONE_C;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      step_q    <= '0;
      meet_q    <= '0;
      timeout_q <= 1'b0;
      init_q    <= '0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      meet_q    <= meet_d;
      timeout_q <= timeout_d;
      init_q    <= init_d;
    end
  end

`ifdef GNR_CTRL_PERIOD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_q    <= '0;
      period_q <= '0;
    end else begin
      per_q    <= per_d;
      period_q <= period_d;
    end
  end
  assign host.period = period_q;
`else
  assign host.period = '0;
`endif

  assign reset_nos      = (state_q == S_LOAD);
  assign init_state     = init_q;
  assign host.busy      = (state_q != S_IDLE);
  assign host.done      = (state_q == S_DONE);
  assign host.timeout   = timeout_q;
  assign host.meet_step = meet_q;

endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// tb/tb_gnr_attractor_ctrl.sv - self-checking bench with a 4-node table-driven network model
module tb_gnr_attractor_ctrl;

  localparam int NN = 4;
  localparam int CW = 16;
  localparam int MS = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gnr_attractor_ctrl_if #(.NUM_NODES(NN), .CNT_W(CW)) host ();

  logic [NN-1:0] s0_vec, s1_vec, init_state;
  logic          reset_nos, start_s0, start_s1;

  gnr_attractor_ctrl #(.NUM_NODES(NN), .CNT_W(CW), .MAX_STEPS(MS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .host       (host.slave),
    .s0_vec     (s0_vec),
    .s1_vec     (s1_vec),
    .reset_nos  (reset_nos),
    .init_state (init_state),
    .start_s0   (start_s0),
    .start_s1   (start_s1)
  );

  // Network next-state table: next = tbl[state].
  logic [3:0] tbl [16];
  logic       pass;
  int         n_s0 = 0, n_s1 = 0, n_ld = 0;

  always @(posedge clk) begin
    if (reset_nos) begin
      s0_vec <= init_state;
      s1_vec <= init_state;
      pass   <= 1'b0;
      n_s0   <= 0;
      n_s1   <= 0;
    end else begin
      if (start_s1) begin
        s1_vec <= tbl[s1_vec];
        n_s1   <= n_s1 + 1;
      end
      if (start_s0) begin
        if (!pass) s0_vec <= tbl[s0_vec];
        pass <= ~pass;
        n_s0 <= n_s0 + 1;
      end
    end
    if (host.start && !host.busy) n_ld <= 0;
    else if (reset_nos) n_ld <= n_ld + 1;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] fp(input logic [3:0] x, input int n);
    logic [3:0] y;
    y = x;
    for (int i = 0; i < n; i++) y = tbl[y];
    return y;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {host.busy, host.done, host.timeout, reset_nos, start_s0, start_s1, init_state}, 0);
    chk({tag, "_res"}, {host.meet_step, host.period}, 0);
  endtask

  // Runs one job; inj != 0 pulses start with a different init at that cycle.
  task automatic run_job(input string tag, input logic [3:0] x, input int inj);
    int c, p, k, e_meet, e_per, cyc;
    bit e_to, per_ph;
    c = 0; p = 0; e_meet = 0; e_per = 0; e_to = 0; per_ph = 0;
    while (1) begin
      if (c > 0 && c % 2 == 0 && fp(x, c) == fp(x, c / 2)) begin e_meet = c; break; end
      if (c == MS) begin e_to = 1; break; end
      c++;
    end
`ifdef GNR_CTRL_PERIOD_EN
    if (!e_to) begin
      per_ph = 1;
      while (1) begin
        if (p != 0 && fp(x, e_meet + p) == fp(x, e_meet / 2)) begin e_per = p; break; end
        if (p == MS) begin e_to = 1; break; end
        p++;
      end
    end
`endif
    k = 1 + (c + 1) + (per_ph ? p + 1 : 0);

    @(negedge clk);
    host.start   = 1'b1;
    host.init_in = x;
    @(posedge clk);
    @(negedge clk);
    host.start   = 1'b0;
    host.init_in = 4'($urandom);
    chk({tag, "_load"}, {host.busy, reset_nos, start_s0, start_s1}, 4'b1100);
    cyc = 0;
    while (host.done !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (inj != 0 && cyc == inj) begin
        host.start   = 1'b1;
        host.init_in = ~x;
      end else begin
        host.start = 1'b0;
      end
    end
    host.start = 1'b0;
    chk({tag, "_latency"}, cyc, k);
    chk({tag, "_timeout"}, host.timeout, e_to);
    chk({tag, "_meet"}, host.meet_step, e_meet);
    chk({tag, "_period"}, host.period, e_per);
    chk({tag, "_init"}, init_state, x);
    chk({tag, "_n_s0"}, n_s0, c);
    chk({tag, "_n_s1"}, n_s1, c + p);
    chk({tag, "_n_ld"}, n_ld, 1);
    @(negedge clk);
    chk({tag, "_after"}, {host.done, host.busy}, 2'b00);
  endtask

  initial begin
    host.start   = 1'b0;
    host.init_in = '0;
    for (int i = 0; i < 16; i++) tbl[i] = 4'(i);
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("idle");

    run_job("fixed", 4'b1010, 0);

    for (int i = 0; i < 16; i++) tbl[i] = (i < 3) ? 4'((i + 1) % 3) : 4'd0;
    run_job("cyc3", 4'd0, 0);
    run_job("busy_start", 4'd0, 3);

    for (int i = 0; i < 16; i++) tbl[i] = 4'((i + 1) % 16);
    run_job("tmo", 4'd0, 0);

    for (int i = 0; i < 16; i++) tbl[i] = (i < 3) ? 4'((i + 1) % 3) : 4'd0;
    @(negedge clk);
    host.start   = 1'b1;
    host.init_in = 4'd0;
    @(posedge clk);
    @(negedge clk);
    host.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_steps", n_s1, 3);
    rst_n = 1'b0;
    #1;
    chk_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_job("post_reset", 4'd0, 0);

    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 16; i++) tbl[i] = 4'($urandom_range(0, 15));
      run_job("rand", 4'($urandom), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
